// File: rtl/rv_hazard_unit.sv
// Pipeline hazard unit: reset flush, load-use interlock, redirect flush, illegal-instruction trap and operand bypass select.
// Optional performance counters are compiled in when RV_HAZARD_PERF_EN is defined.
module rv_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int N_FWD     = 3,
  parameter int RST_FLUSH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_fetch_bus_ack,
  input  logic [REG_AW-1:0]           i_decode_rs1,
  input  logic [REG_AW-1:0]           i_decode_rs2,
  input  logic                        i_decode_inv_instr,
  input  logic [REG_AW-1:0]           i_exec_rs1,
  input  logic [REG_AW-1:0]           i_exec_rs2,
  input  logic [REG_AW-1:0]           i_exec_rd,
  input  logic                        i_exec_is_load,
  input  logic                        i_exec_pc_sel,
  input  logic                        i_mem_ack,
  input  logic [N_FWD*REG_AW-1:0]     i_fwd_rd,
  input  logic [N_FWD-1:0]            i_fwd_we,
  output logic [$clog2(N_FWD+1)-1:0]  o_exec_bp_rs1,
  output logic [$clog2(N_FWD+1)-1:0]  o_exec_bp_rs2,
  output logic                        o_fetch_stall,
  output logic                        o_decode_stall,
  output logic                        o_decode_flush,
  output logic                        o_exec_flush,
  output logic                        o_inv_instr
`ifdef RV_HAZARD_PERF_EN
  ,
  output logic [31:0]                 o_perf_stall_cnt,
  output logic [31:0]                 o_perf_flush_cnt
`endif
);

  localparam int BP_W = $clog2(N_FWD+1);

  typedef enum logic [1:0] {
    RST_FL  = 2'd0,
    RUN     = 2'd1,
    LD_WAIT = 2'd2,
    TRAP    = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  flush_cnt_reg;
  logic        load_use;
  logic [N_FWD-1:0] hit_rs1, hit_rs2;
  logic [BP_W-1:0]  bp_rs1, bp_rs2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= RST_FL;
      flush_cnt_reg <= 4'(RST_FLUSH - 1);
    end else begin
      state_reg <= state_next;
      if (state_reg == RST_FL && flush_cnt_reg != 4'd0)
        flush_cnt_reg <= flush_cnt_reg - 4'd1;
    end
  end

  assign load_use = i_exec_is_load && (i_exec_rd != '0) &&
                    ((i_exec_rd == i_decode_rs1) || (i_exec_rd == i_decode_rs2));

  for (genvar gi = 0; gi < N_FWD; gi++) begin : g_fwd
    assign hit_rs1[gi] = i_fwd_we[gi] && (i_fwd_rd[gi*REG_AW +: REG_AW] == i_exec_rs1) &&
                         (i_exec_rs1 != '0);
    assign hit_rs2[gi] = i_fwd_we[gi] && (i_fwd_rd[gi*REG_AW +: REG_AW] == i_exec_rs2) &&
                         (i_exec_rs2 != '0);
  end

  // Scan oldest to youngest so the youngest matching source wins.
  always_comb begin
    bp_rs1 = '0;
    bp_rs2 = '0;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (hit_rs1[i]) bp_rs1 = BP_W'(i + 1);
      if (hit_rs2[i]) bp_rs2 = BP_W'(i + 1);
    end
  end

  always_comb begin
    state_next     = state_reg;
    o_fetch_stall  = 1'b0;
    o_decode_stall = 1'b0;
    o_decode_flush = 1'b0;
    o_exec_flush   = 1'b0;
    o_inv_instr    = 1'b0;
    o_exec_bp_rs1  = '0;
    o_exec_bp_rs2  = '0;
    case (state_reg)
      RST_FL: begin
        o_fetch_stall  = 1'b1;
        o_decode_stall = 1'b1;
        o_decode_flush = 1'b1;
        o_exec_flush   = 1'b1;
        if (flush_cnt_reg == 4'd0) state_next = RUN;
      end
      RUN: begin
        o_exec_bp_rs1 = bp_rs1;
        o_exec_bp_rs2 = bp_rs2;
        if (!i_fetch_bus_ack) begin
          o_fetch_stall  = 1'b1;
          o_decode_stall = 1'b1;
          o_exec_flush   = 1'b1;
        end
        // A redirect squashes decode, so neither its illegal flag nor a load-use match counts.
        if (i_exec_pc_sel) begin
          o_decode_flush = 1'b1;
          o_exec_flush   = 1'b1;
        end else if (i_decode_inv_instr) begin
          state_next = TRAP;
        end else if (load_use) begin
          o_fetch_stall  = 1'b1;
          o_decode_stall = 1'b1;
          o_exec_flush   = 1'b1;
          state_next     = LD_WAIT;
        end
        if (load_use && !i_exec_pc_sel) begin
          o_fetch_stall  = 1'b1;
          o_decode_stall = 1'b1;
          o_exec_flush   = 1'b1;
        end
      end
      LD_WAIT: begin
        o_exec_bp_rs1  = bp_rs1;
        o_exec_bp_rs2  = bp_rs2;
        o_fetch_stall  = 1'b1;
        o_decode_stall = 1'b1;
        o_exec_flush   = 1'b1;
        if (i_decode_inv_instr)  state_next = TRAP;
        else if (i_mem_ack)      state_next = RUN;
      end
      TRAP: begin
        o_fetch_stall  = 1'b1;
        o_decode_stall = 1'b1;
        o_decode_flush = 1'b1;
        o_exec_flush   = 1'b1;
        o_inv_instr    = 1'b1;
      end
      default: state_next = RST_FL;
    endcase
  end

`ifdef RV_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt_reg;
  logic [31:0] perf_flush_cnt_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      perf_stall_cnt_reg <= '0;
      perf_flush_cnt_reg <= '0;
    end else begin
      if ((state_reg == RUN || state_reg == LD_WAIT) && o_fetch_stall &&
          perf_stall_cnt_reg != 32'hFFFF_FFFF)
        perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
      if (state_reg == RUN && i_exec_pc_sel && perf_flush_cnt_reg != 32'hFFFF_FFFF)
        perf_flush_cnt_reg <= perf_flush_cnt_reg + 32'd1;
    end
  end

  assign o_perf_stall_cnt = perf_stall_cnt_reg;
  assign o_perf_flush_cnt = perf_flush_cnt_reg;
`endif

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Scoreboard bench for rv_hazard_unit: a per-cycle reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_rv_hazard_unit;
  localparam int REG_AW    = 5;
  localparam int N_FWD     = 3;
  localparam int RST_FLUSH = 2;
  localparam int BPW       = $clog2(N_FWD+1);

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic                    i_reset;
  logic                    i_fetch_bus_ack;
  logic [REG_AW-1:0]       i_decode_rs1, i_decode_rs2;
  logic                    i_decode_inv_instr;
  logic [REG_AW-1:0]       i_exec_rs1, i_exec_rs2, i_exec_rd;
  logic                    i_exec_is_load, i_exec_pc_sel, i_mem_ack;
  logic [N_FWD*REG_AW-1:0] i_fwd_rd;
  logic [N_FWD-1:0]        i_fwd_we;
  logic [BPW-1:0]          o_exec_bp_rs1, o_exec_bp_rs2;
  logic o_fetch_stall, o_decode_stall, o_decode_flush, o_exec_flush, o_inv_instr;
`ifdef RV_HAZARD_PERF_EN
  logic [31:0] o_perf_stall_cnt, o_perf_flush_cnt;
`endif

  rv_hazard_unit #(.REG_AW(REG_AW), .N_FWD(N_FWD), .RST_FLUSH(RST_FLUSH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_fetch_bus_ack(i_fetch_bus_ack),
    .i_decode_rs1(i_decode_rs1), .i_decode_rs2(i_decode_rs2),
    .i_decode_inv_instr(i_decode_inv_instr),
    .i_exec_rs1(i_exec_rs1), .i_exec_rs2(i_exec_rs2), .i_exec_rd(i_exec_rd),
    .i_exec_is_load(i_exec_is_load), .i_exec_pc_sel(i_exec_pc_sel), .i_mem_ack(i_mem_ack),
    .i_fwd_rd(i_fwd_rd), .i_fwd_we(i_fwd_we),
    .o_exec_bp_rs1(o_exec_bp_rs1), .o_exec_bp_rs2(o_exec_bp_rs2),
    .o_fetch_stall(o_fetch_stall), .o_decode_stall(o_decode_stall),
    .o_decode_flush(o_decode_flush), .o_exec_flush(o_exec_flush),
    .o_inv_instr(o_inv_instr)
`ifdef RV_HAZARD_PERF_EN
    , .o_perf_stall_cnt(o_perf_stall_cnt), .o_perf_flush_cnt(o_perf_flush_cnt)
`endif
  );

  typedef struct packed {
    logic rst, fetch_ack;
    logic [REG_AW-1:0] d_rs1, d_rs2;
    logic d_inv;
    logic [REG_AW-1:0] e_rs1, e_rs2, e_rd;
    logic e_load, pc_sel, mem_ack;
    logic [N_FWD*REG_AW-1:0] fwd_rd;
    logic [N_FWD-1:0] fwd_we;
  } stim_t;

  typedef struct packed {
    logic fs, ds, df, ef, inv;
    logic [BPW-1:0] bp1, bp2;
    logic [31:0] pst, pfl;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: remaining flush cycles, plus two plain flags.
  int          flush_left = RST_FLUSH;
  bit          trapped    = 1'b0;
  bit          waiting    = 1'b0;
  logic [31:0] perf_stall = '0;
  logic [31:0] perf_flush = '0;

  function automatic logic [BPW-1:0] ref_bp(input logic [REG_AW-1:0] opnd,
                                            input logic [N_FWD*REG_AW-1:0] rd,
                                            input logic [N_FWD-1:0] we);
    if (opnd == 0) return '0;
    for (int i = 0; i < N_FWD; i++)
      if (we[i] && rd[i*REG_AW +: REG_AW] == opnd) return BPW'(i + 1);
    return '0;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   haz;
    @(posedge i_clk);
    #1;
    i_reset = s.rst;          i_fetch_bus_ack = s.fetch_ack;
    i_decode_rs1 = s.d_rs1;   i_decode_rs2 = s.d_rs2;   i_decode_inv_instr = s.d_inv;
    i_exec_rs1 = s.e_rs1;     i_exec_rs2 = s.e_rs2;     i_exec_rd = s.e_rd;
    i_exec_is_load = s.e_load; i_exec_pc_sel = s.pc_sel; i_mem_ack = s.mem_ack;
    i_fwd_rd = s.fwd_rd;      i_fwd_we = s.fwd_we;
    e = '0;
    if (s.rst) begin
      flush_left = RST_FLUSH; trapped = 0; waiting = 0; perf_stall = '0; perf_flush = '0;
    end
    e.pst = perf_stall;
    e.pfl = perf_flush;
    if (flush_left > 0) begin
      {e.fs, e.ds, e.df, e.ef} = 4'b1111;
      if (!s.rst) flush_left--;
    end else if (trapped) begin
      {e.fs, e.ds, e.df, e.ef, e.inv} = 5'b11111;
    end else begin
      e.bp1 = ref_bp(s.e_rs1, s.fwd_rd, s.fwd_we);
      e.bp2 = ref_bp(s.e_rs2, s.fwd_rd, s.fwd_we);
      if (waiting) begin
        {e.fs, e.ds, e.ef} = 3'b111;
        if (s.d_inv) trapped = 1;
        else if (s.mem_ack) waiting = 0;
      end else begin
        haz  = s.e_load && s.e_rd != 0 && (s.e_rd == s.d_rs1 || s.e_rd == s.d_rs2);
        e.fs = !s.fetch_ack || (haz && !s.pc_sel);
        e.ds = e.fs;
        e.df = s.pc_sel;
        e.ef = e.fs || s.pc_sel;
        if (s.pc_sel) perf_flush = sat_inc(perf_flush);
        if (s.d_inv && !s.pc_sel) trapped = 1;
        else if (haz && !s.pc_sel) waiting = 1;
      end
      if (e.fs) perf_stall = sat_inc(perf_stall);
    end
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle_stim();
    stim_t s = '0;
    s.fetch_ack = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst       = ($urandom_range(0, 79) == 0);
    s.fetch_ack = ($urandom_range(0, 5) != 0);
    s.d_rs1     = REG_AW'($urandom_range(0, 3));
    s.d_rs2     = REG_AW'($urandom_range(0, 3));
    s.d_inv     = ($urandom_range(0, 49) == 0);
    s.e_rs1     = REG_AW'($urandom_range(0, 3));
    s.e_rs2     = REG_AW'($urandom_range(0, 3));
    s.e_rd      = REG_AW'($urandom_range(0, 3));
    s.e_load    = $urandom_range(0, 1) == 1;
    s.pc_sel    = ($urandom_range(0, 5) == 0);
    s.mem_ack   = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < N_FWD; i++) s.fwd_rd[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
    s.fwd_we    = N_FWD'($urandom_range(0, (1 << N_FWD) - 1));
    return s;
  endfunction

  // Monitor: one comparison per presented output vector.
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '0;
      {a.fs, a.ds, a.df, a.ef, a.inv} =
        {o_fetch_stall, o_decode_stall, o_decode_flush, o_exec_flush, o_inv_instr};
      a.bp1 = o_exec_bp_rs1;
      a.bp2 = o_exec_bp_rs2;
`ifdef RV_HAZARD_PERF_EN
      a.pst = o_perf_stall_cnt;
      a.pfl = o_perf_flush_cnt;
`else
      a.pst = e.pst;
      a.pfl = e.pfl;
`endif
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec %0d outputs: got fs/ds/df/ef/inv=%b bp=%0d/%0d perf=%0d/%0d, expected %b bp=%0d/%0d perf=%0d/%0d",
                 vectors, {a.fs, a.ds, a.df, a.ef, a.inv}, a.bp1, a.bp2, a.pst, a.pfl,
                 {e.fs, e.ds, e.df, e.ef, e.inv}, e.bp1, e.bp2, e.pst, e.pfl);
      end else begin
        $display("vec %0d ok: fs/ds/df/ef/inv=%b bp=%0d/%0d", vectors,
                 {a.fs, a.ds, a.df, a.ef, a.inv}, a.bp1, a.bp2);
      end
    end
  end

  initial begin
    stim_t s;
    {i_fetch_bus_ack, i_decode_rs1, i_decode_rs2, i_decode_inv_instr} = '0;
    {i_exec_rs1, i_exec_rs2, i_exec_rd, i_exec_is_load, i_exec_pc_sel, i_mem_ack} = '0;
    i_fwd_rd = '0;
    i_fwd_we = '0;
    i_reset  = 1'b1;

    // Reset then flush window and idle run.
    s = idle_stim(); s.rst = 1'b1;
    repeat (2) step(s);
    s = idle_stim();
    repeat (4) step(s);

    // Load-use: one bubble, two waits, then data returns.
    s = idle_stim(); s.e_load = 1'b1; s.e_rd = 5'd5; s.d_rs2 = 5'd5;
    step(s);
    s = idle_stim();
    repeat (2) step(s);
    s.mem_ack = 1'b1;
    step(s);
    s = idle_stim();
    step(s);

    // Forwarding priority and x0 exclusion.
    s = idle_stim(); s.e_rs1 = 5'd7; s.fwd_we = 3'b110; s.fwd_rd = {5'd7, 5'd7, 5'd3};
    step(s);
    s.e_rs1 = 5'd0;
    step(s);
    s.e_rs2 = 5'd3; s.fwd_we = 3'b111;
    step(s);

    // Redirect coincident with a load-use match.
    s = idle_stim(); s.pc_sel = 1'b1; s.e_load = 1'b1; s.e_rd = 5'd4; s.d_rs1 = 5'd4;
    step(s);
    s = idle_stim();
    step(s);

    // Illegal instruction under redirect is ignored, then traps and sticks.
    s = idle_stim(); s.d_inv = 1'b1; s.pc_sel = 1'b1;
    step(s);
    s.pc_sel = 1'b0; s.e_load = 1'b1; s.e_rd = 5'd2; s.d_rs1 = 5'd2;
    step(s);
    for (int i = 0; i < 100; i++) begin
      s = rand_stim(); s.rst = 1'b0;
      step(s);
    end
    s = idle_stim(); s.rst = 1'b1;
    step(s);
    s = idle_stim();
    repeat (4) step(s);

`ifdef RV_HAZARD_PERF_EN
    // Preload the stall counter near its ceiling and drive it into saturation.
    @(negedge i_clk);
    #1;
    dut.perf_stall_cnt_reg = 32'hFFFF_FFFD;
    perf_stall = 32'hFFFF_FFFD;
    s = idle_stim(); s.fetch_ack = 1'b0;
    repeat (6) step(s);
`endif

    for (int i = 0; i < 1000; i++) step(rand_stim());

    repeat (3) @(negedge i_clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rv_hazard_unit.md
RV_HAZARD_UNIT -- requirements
Module: rv_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width (5 = RV32I, 4 = RV32E).
REQ-002 SHALL have parameter N_FWD, default 3, number of forwarding sources; index 0 is youngest.
REQ-003 SHALL have parameter RST_FLUSH, default 2, range 1..15, post-reset flush cycles.
REQ-004 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_fetch_bus_ack  in  1  fetch data valid this cycle.
REQ-007 SHALL have ports i_decode_rs1, i_decode_rs2  in  REG_AW  decode source registers.
REQ-008 SHALL have port i_decode_inv_instr  in  1  decode holds an illegal encoding.
REQ-009 SHALL have ports i_exec_rs1, i_exec_rs2, i_exec_rd  in  REG_AW  execute operands and destination.
REQ-010 SHALL have port i_exec_is_load  in  1  execute holds a load.
REQ-011 SHALL have port i_exec_pc_sel  in  1  execute redirects the PC.
REQ-012 SHALL have port i_mem_ack  in  1  load data returned.
REQ-013 SHALL have ports i_fwd_rd  in  N_FWD*REG_AW and i_fwd_we  in  N_FWD  forwarding-source destinations and write enables; slot i = bits [i*REG_AW +: REG_AW].
REQ-014 SHALL have ports o_exec_bp_rs1, o_exec_bp_rs2  out  $clog2(N_FWD+1)  bypass select: 0 = register file, i+1 = source i.
REQ-015 SHALL have ports o_fetch_stall, o_decode_stall, o_decode_flush, o_exec_flush, o_inv_instr  out  1 each.

Function
REQ-016 SHALL implement a 4-state FSM: RST_FL=0, RUN=1, LD_WAIT=2, TRAP=3.
REQ-017 RST_FL SHALL assert all four stall/flush outputs, decrement a flush counter loaded with RST_FLUSH-1, and go to RUN on the edge where the counter is 0.
REQ-018 RUN load-use hazard SHALL be i_exec_is_load & (i_exec_rd != 0) & (i_exec_rd == i_decode_rs1 | i_exec_rd == i_decode_rs2).
REQ-019 RUN with hazard and no pc_sel SHALL assert o_fetch_stall, o_decode_stall and o_exec_flush in the same cycle, then enter LD_WAIT.
REQ-020 LD_WAIT SHALL hold the same three outputs and return to RUN on the edge where i_mem_ack=1; i_mem_ack in RUN SHALL be ignored.
REQ-021 RUN with i_exec_pc_sel=1 SHALL assert o_decode_flush and o_exec_flush, SHALL suppress load-use entry, and the FSM SHALL stay in RUN.
REQ-022 RUN with i_fetch_bus_ack=0 SHALL assert o_fetch_stall, o_decode_stall and o_exec_flush without a state change.
REQ-023 i_decode_inv_instr=1 in RUN or LD_WAIT, with o_decode_flush=0 that cycle, SHALL enter TRAP; TRAP takes priority over a same-cycle load-use hazard.
REQ-024 TRAP SHALL be sticky until reset, SHALL assert all four stall/flush outputs, and SHALL assert o_inv_instr=1; o_inv_instr SHALL be 0 in every other state.
REQ-025 Forwarding SHALL select, per operand, the lowest i with i_fwd_we[i] & (i_fwd_rd slot i == operand) & (operand != 0); the output is i+1, otherwise 0.
REQ-026 Forwarding selects SHALL be combinational, zero latency, and forced to 0 in RST_FL and TRAP.
REQ-027 All other outputs SHALL be combinational functions of state and inputs; no output SHALL be registered.

Reset
REQ-028 i_reset=1 SHALL immediately force state RST_FL and load the flush counter with RST_FLUSH-1, including mid-LD_WAIT and from TRAP.
REQ-029 During and right after reset the outputs SHALL be: stalls=1, flushes=1, o_inv_instr=0, bypass selects=0.

Configuration
REQ-030 Macro RV_HAZARD_PERF_EN defined SHALL add outputs o_perf_stall_cnt (32 bits, counts cycles in RUN/LD_WAIT with o_fetch_stall=1) and o_perf_flush_cnt (32 bits, counts cycles with i_exec_pc_sel=1 in RUN).
REQ-031 Both counters SHALL saturate at 0xFFFFFFFF and clear on i_reset.
REQ-032 With RV_HAZARD_PERF_EN undefined, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Release reset with RST_FLUSH=2 -> flushes high for exactly 2 cycles, then RUN with all outputs 0 when fetch_ack=1.
REQ-034 exec load rd=5, decode rs2=5 -> 1 bubble cycle; 3 LD_WAIT cycles then mem_ack=1 -> 4 stall cycles total, then RUN.
REQ-035 exec rs1=7, fwd_we=3'b110, fwd_rd slots 1 and 2 = 7 -> o_exec_bp_rs1=2; with exec rs1=0 -> 0.
REQ-036 pc_sel=1 together with load-use hazard -> both flushes high, no stall, state stays RUN.
REQ-037 inv_instr=1 with pc_sel=0 -> TRAP, o_inv_instr=1 held for 100 cycles; i_reset pulse -> RST_FL, o_inv_instr=0.
REQ-038 With RV_HAZARD_PERF_EN, run the REQ-034 scenario -> o_perf_stall_cnt=4; after a preload near 0xFFFFFFFF, the counter holds at saturation.
